// File: rtl/temp_sample_if.sv
// Bundle between the temperature sequencer, the sensor, the tconvert datapath and the display.
// MIN_MAX_EN adds the min/max clear input and the signed min/max outputs.
interface temp_sample_if;
    localparam int unsigned TC_W = 13;
    localparam int unsigned TX_W = 18;

    logic            unit_tgl;
    logic            force_smp;
    logic            sns_start;
    logic            sns_done;
    logic [TC_W-1:0] sns_data;
    logic [TC_W-1:0] conv_tc;
    logic            conv_cf;
    logic [TX_W-1:0] conv_tx10;
    logic [TX_W-1:0] disp_tx10;
    logic            disp_cf;
    logic            disp_upd;
    logic            sns_err;
`ifdef MIN_MAX_EN
    logic            clr_mm;
    logic [TX_W-1:0] disp_min;
    logic [TX_W-1:0] disp_max;
`endif

    // Sequencer side
    modport master (
        input  unit_tgl, force_smp, sns_done, sns_data, conv_tx10,
`ifdef MIN_MAX_EN
        input  clr_mm,
        output disp_min, disp_max,
`endif
        output sns_start, conv_tc, conv_cf, disp_tx10, disp_cf, disp_upd, sns_err
    );

    // Environment side (sensor, converter, display, user controls)
    modport slave (
        output unit_tgl, force_smp, sns_done, sns_data, conv_tx10,
`ifdef MIN_MAX_EN
        output clr_mm,
        input  disp_min, disp_max,
`endif
        input  sns_start, conv_tc, conv_cf, disp_tx10, disp_cf, disp_upd, sns_err
    );
endinterface

// File: rtl/temp_sample_ctrl.sv
// Temperature sample sequencer: sensor start/wait, tconvert hand-off, display latch, timeout flag.
// Define MIN_MAX_EN to add signed min/max tracking of the displayed temperature.
module temp_sample_ctrl #(
    parameter int unsigned SAMPLE_PERIOD = 1_000_000,
    parameter int unsigned TIMEOUT       = 1000,
    parameter int unsigned CONV_LAT      = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    temp_sample_if.master bus
);
    localparam int unsigned TC_W   = 13;
    localparam int unsigned TX_W   = 18;
    localparam int unsigned PCNT_W = $clog2(SAMPLE_PERIOD);
    localparam int unsigned STEP_N = (TIMEOUT > CONV_LAT) ? TIMEOUT : CONV_LAT;
    localparam int unsigned SCNT_W = (STEP_N > 1) ? $clog2(STEP_N) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [SCNT_W-1:0] TMO_LAST  = SCNT_W'(TIMEOUT - 1);
    localparam logic [SCNT_W-1:0] CONV_LAST = SCNT_W'(CONV_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_CONV  = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [PCNT_W-1:0] pcnt_q,      pcnt_d;
    logic [SCNT_W-1:0] scnt_q,      scnt_d;
    logic              unit_q,      unit_d;
    logic              sns_start_q, sns_start_d;
    logic [TC_W-1:0]   conv_tc_q,   conv_tc_d;
    logic              conv_cf_q,   conv_cf_d;
    logic [TX_W-1:0]   disp_tx10_q, disp_tx10_d;
    logic              disp_cf_q,   disp_cf_d;
    logic              disp_upd_q,  disp_upd_d;
    logic              sns_err_q,   sns_err_d;

    // Next-state and next-output logic; the scnt counter is shared by WAIT (timeout) and CONV (latency)
    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        scnt_d      = scnt_q;
        unit_d      = unit_q ^ bus.unit_tgl;
        sns_start_d = 1'b0;
        conv_tc_d   = conv_tc_q;
        conv_cf_d   = conv_cf_q;
        disp_tx10_d = disp_tx10_q;
        disp_cf_d   = disp_cf_q;
        disp_upd_d  = 1'b0;
        sns_err_d   = sns_err_q;

        unique case (state_q)
            S_IDLE: begin
                if ((pcnt_q == PCNT_LAST) || bus.force_smp) begin
                    state_d     = S_START;
                    pcnt_d      = '0;
                    sns_start_d = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + PCNT_W'(1);
                end
            end
            S_START: begin
                state_d = S_WAIT;
                scnt_d  = '0;
            end
            S_WAIT: begin
                // A done arriving on the timeout cycle still counts as a good sample
                if (bus.sns_done) begin
                    conv_tc_d = bus.sns_data;
                    conv_cf_d = unit_q;
                    scnt_d    = '0;
                    state_d   = S_CONV;
                end else if (scnt_q == TMO_LAST) begin
                    sns_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end
            S_CONV: begin
                if (scnt_q == CONV_LAST) begin
                    disp_tx10_d = bus.conv_tx10;
                    disp_cf_d   = conv_cf_q;
                    disp_upd_d  = 1'b1;
                    sns_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pcnt_q      <= '0;
            scnt_q      <= '0;
            unit_q      <= 1'b0;
            sns_start_q <= 1'b0;
            conv_tc_q   <= '0;
            conv_cf_q   <= 1'b0;
            disp_tx10_q <= '0;
            disp_cf_q   <= 1'b0;
            disp_upd_q  <= 1'b0;
            sns_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            scnt_q      <= scnt_d;
            unit_q      <= unit_d;
            sns_start_q <= sns_start_d;
            conv_tc_q   <= conv_tc_d;
            conv_cf_q   <= conv_cf_d;
            disp_tx10_q <= disp_tx10_d;
            disp_cf_q   <= disp_cf_d;
            disp_upd_q  <= disp_upd_d;
            sns_err_q   <= sns_err_d;
        end
    end

    assign bus.sns_start = sns_start_q;
    assign bus.conv_tc   = conv_tc_q;
    assign bus.conv_cf   = conv_cf_q;
    assign bus.disp_tx10 = disp_tx10_q;
    assign bus.disp_cf   = disp_cf_q;
    assign bus.disp_upd  = disp_upd_q;
    assign bus.sns_err   = sns_err_q;

`ifdef MIN_MAX_EN
    logic                   mm_empty_q, mm_empty_d;
    logic signed [TX_W-1:0] mm_min_q,   mm_min_d;
    logic signed [TX_W-1:0] mm_max_q,   mm_max_d;
    logic signed [TX_W-1:0] tx_new;

    assign tx_new = $signed(bus.conv_tx10);

    // Min/max restart on empty, clear or unit change; otherwise widen by signed compare
    always_comb begin
        mm_empty_d = mm_empty_q;
        mm_min_d   = mm_min_q;
        mm_max_d   = mm_max_q;
        if (disp_upd_d) begin
            mm_empty_d = 1'b0;
            if (mm_empty_q || bus.clr_mm || (disp_cf_d != disp_cf_q)) begin
                mm_min_d = tx_new;
                mm_max_d = tx_new;
            end else begin
                if (tx_new < mm_min_q) mm_min_d = tx_new;
                if (tx_new > mm_max_q) mm_max_d = tx_new;
            end
        end else if (bus.clr_mm) begin
            mm_empty_d = 1'b1;
            mm_min_d   = '0;
            mm_max_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_empty_q <= 1'b1;
            mm_min_q   <= '0;
            mm_max_q   <= '0;
        end else begin
            mm_empty_q <= mm_empty_d;
            mm_min_q   <= mm_min_d;
            mm_max_q   <= mm_max_d;
        end
    end

    assign bus.disp_min = mm_min_q;
    assign bus.disp_max = mm_max_q;
`endif
endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Randomized self-checking bench for temp_sample_ctrl against a transaction-level model.
// Build with MIN_MAX_EN defined to also check the min/max tracker.
`timescale 1ns/1ps
module tb_temp_sample_ctrl;
    localparam int unsigned SP  = 20;
    localparam int unsigned TMO = 8;
    localparam int unsigned CL  = 2;

    logic clk;
    logic rst_n;
    logic signed [17:0] tc_ext;

    temp_sample_if bus ();

    temp_sample_ctrl #(
        .SAMPLE_PERIOD(SP),
        .TIMEOUT      (TMO),
        .CONV_LAT     (CL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Converter stub: tx10 = tc * 10 (signed)
    assign tc_ext        = 18'($signed(bus.conv_tc));
    assign bus.conv_tx10 = tc_ext * 18'sd10;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_unit, m_tx10, m_cf, m_err;
    int m_empty, m_min, m_max;
    int idle_el;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        bus.unit_tgl  = 1'b0;
        bus.force_smp = 1'b0;
        bus.sns_done  = 1'b0;
`ifdef MIN_MAX_EN
        bus.clr_mm    = 1'b0;
`endif
    endtask

    task automatic model_reset();
        m_unit = 0; m_tx10 = 0; m_cf = 0; m_err = 0;
        m_empty = 1; m_min = 0; m_max = 0;
    endtask

    task automatic check_disp(input string tag);
        chk({tag, "_tx10"}, int'($signed(bus.disp_tx10)), m_tx10);
        chk({tag, "_cf"},   bus.disp_cf, m_cf);
        chk({tag, "_err"},  bus.sns_err, m_err);
`ifdef MIN_MAX_EN
        chk({tag, "_min"},  int'($signed(bus.disp_min)), m_min);
        chk({tag, "_max"},  int'($signed(bus.disp_max)), m_max);
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_start"}, bus.sns_start, 0);
        chk({tag, "_tc"},    bus.conv_tc, 0);
        chk({tag, "_ccf"},   bus.conv_cf, 0);
        chk({tag, "_upd"},   bus.disp_upd, 0);
        check_disp(tag);
    endtask

    // Wait for sns_start from IDLE; expected latency comes from the elapsed idle time
    task automatic wait_start(input bit forced);
        int lat;
        int exp_lat;
        exp_lat = forced ? 1 : int'(SP) - idle_el;
        if (forced) bus.force_smp = 1'b1;
        if ($urandom_range(0, 3) == 0) bus.sns_done = 1'b1;
        if ($urandom_range(0, 3) == 0) begin bus.unit_tgl = 1'b1; m_unit ^= 1; end
        lat = 0;
        do begin
            tick();
            lat++;
            if (!bus.sns_start) chk("idle_no_upd", bus.disp_upd, 0);
        end while (!bus.sns_start && lat < int'(SP) + 4);
        chk("start_latency", lat, exp_lat);
    endtask

    // One full sample; d=0 means the sensor never answers, t=0 means no toggle in WAIT
    task automatic do_sample(input bit forced, input int d, input logic [12:0] data,
                             input int t, input bit clr_upd, input bit rst_conv);
        int cap;
        int v;
        int prev_cf;
        wait_start(forced);
        cap = -1;
        for (int j = 1; j <= int'(TMO) && cap < 0; j++) begin
            tick();
            if (j == 1) chk("start_width", bus.sns_start, 0);
            chk("wait_no_upd", bus.disp_upd, 0);
            bus.sns_data = 13'($urandom);
            if (j == d) begin bus.sns_done = 1'b1; bus.sns_data = data; cap = m_unit; end
            if (j == t) begin bus.unit_tgl = 1'b1; m_unit ^= 1; end
            if ($urandom_range(0, 4) == 0) bus.force_smp = 1'b1;
        end
        if (cap < 0) begin
            tick();
            m_err   = 1;
            idle_el = 0;
            chk("tmo_no_upd", bus.disp_upd, 0);
            check_disp("tmo");
        end else begin
            tick();
            chk("conv_tc", bus.conv_tc, data);
            chk("conv_cf", bus.conv_cf, cap);
            chk("conv_no_upd", bus.disp_upd, 0);
            if (rst_conv) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_zero("rst_mid");
                tick();
                chk("rst_no_upd", bus.disp_upd, 0);
                rst_n   = 1'b1;
                idle_el = 0;
            end else begin
                for (int k = 1; k <= int'(CL); k++) begin
                    if (k > 1) begin
                        tick();
                        chk("conv_hold_tc", bus.conv_tc, data);
                        chk("conv_hold_upd", bus.disp_upd, 0);
                    end
                    bus.sns_data = 13'($urandom);
                    if ($urandom_range(0, 2) == 0) bus.sns_done = 1'b1;
                    if ($urandom_range(0, 2) == 0) bus.force_smp = 1'b1;
                    if ($urandom_range(0, 3) == 0) begin bus.unit_tgl = 1'b1; m_unit ^= 1; end
                end
`ifdef MIN_MAX_EN
                if (clr_upd) bus.clr_mm = 1'b1;
`endif
                tick();
                v       = int'($signed(data)) * 10;
                prev_cf = m_cf;
                m_tx10  = v;
                m_cf    = cap;
                m_err   = 0;
                if (m_empty != 0 || clr_upd || cap != prev_cf) begin
                    m_min = v; m_max = v;
                end else begin
                    if (v < m_min) m_min = v;
                    if (v > m_max) m_max = v;
                end
                m_empty = 0;
                chk("upd_pulse", bus.disp_upd, 1);
                check_disp("upd");
                tick();
                chk("upd_width", bus.disp_upd, 0);
                chk("conv_tc_after", bus.conv_tc, data);
                chk("conv_cf_after", bus.conv_cf, cap);
                idle_el = 1;
            end
        end
    endtask

    // Idle-time controls: unit toggle and (optionally) min/max clear
    task automatic idle_op(input bit tgl, input bit clr);
        if (tgl) begin bus.unit_tgl = 1'b1; m_unit ^= 1; end
`ifdef MIN_MAX_EN
        if (clr) begin bus.clr_mm = 1'b1; m_empty = 1; m_min = 0; m_max = 0; end
`else
        if (clr) m_empty = 1;
`endif
        tick();
        idle_el++;
        chk("idle_op_upd", bus.disp_upd, 0);
        check_disp("idle_op");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.unit_tgl  = 1'b0;
        bus.force_smp = 1'b0;
        bus.sns_done  = 1'b0;
        bus.sns_data  = '0;
`ifdef MIN_MAX_EN
        bus.clr_mm    = 1'b0;
`endif
        model_reset();
        repeat (3) tick();
        check_zero("reset");
        rst_n   = 1'b1;
        idle_el = 0;

        // Auto start after a full period, then forced sample of 25
        do_sample(1'b0, 3, 13'd25, 0, 1'b0, 1'b0);
        do_sample(1'b1, 3, 13'd25, 0, 1'b0, 1'b0);
        // Timeout, then recovery with 30
        do_sample(1'b1, 0, 13'd0, 0, 1'b0, 1'b0);
        do_sample(1'b1, 2, 13'd30, 0, 1'b0, 1'b0);
        // Done on the last WAIT cycle still wins over timeout
        do_sample(1'b1, int'(TMO), 13'd100, 0, 1'b0, 1'b0);
        // Toggle coincident with done: this sample keeps old unit, next one gets the new one
        do_sample(1'b1, 4, 13'd7, 4, 1'b0, 1'b0);
        do_sample(1'b1, 1, 13'd8, 0, 1'b0, 1'b0);
        idle_op(1'b1, 1'b0);
        // Reset during CONV, then auto restart after a full period
        do_sample(1'b1, 2, 13'd15, 0, 1'b0, 1'b1);
        do_sample(1'b0, 5, 13'd40, 0, 1'b0, 1'b0);
        // Min/max sequence: 25, -4, 30; clear; 10; unit change; 12; clear coincident with update
        do_sample(1'b1, 1, 13'd25, 0, 1'b0, 1'b0);
        do_sample(1'b1, 2, 13'h1FFC, 0, 1'b0, 1'b0);
        do_sample(1'b1, 3, 13'd30, 0, 1'b0, 1'b0);
        idle_op(1'b0, 1'b1);
        do_sample(1'b1, 1, 13'd10, 0, 1'b0, 1'b0);
        idle_op(1'b1, 1'b0);
        do_sample(1'b1, 2, 13'd12, 0, 1'b0, 1'b0);
        do_sample(1'b1, 2, 13'd50, 0, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_sample(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, TMO)),
                      13'($urandom), int'($urandom_range(0, TMO)),
                      1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 3) == 0)
                idle_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
